// File: rtl/processing_mem_port2_arbiter.sv
// processing_mem_port2_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter with lock support. Masters m0 (network receive DMA) and
// m1 (transmit DMA) share the 16-bit second port of the dual-port processing
// memory through this block.
//
// The memory registers its address and does not register its output, so read
// data returns one cycle after a granted read. Grants are combinational, which
// means the request cycle is also the access cycle. readdatavalid is a
// registered flag that marks the cycle in which the memory output belongs to
// a given master.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   freeze                stops new grants; the arbiter state is held
//   mN_address/read/write/writedata/byteenable/lock
//                         Avalon-MM master N request side (N = 0, 1)
//   mN_waitrequest        low only in the cycle master N is granted
//   mN_readdata           passthrough of mem_readdata
//   mN_readdatavalid      high in the cycle after a granted read by N
//   mem_address/chipselect/write/writedata/byteenable/clken
//                         memory port 2 controls
//   mem_readdata          memory port 2 read data
// ----------------------------------------------------------------------------
module processing_mem_port2_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int BE_W     = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int HC_W = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0] HC_ONE   = HC_W'(1);
    localparam logic [HC_W-1:0] HC_ZERO  = HC_W'(0);
    localparam logic [HC_W-1:0] HC_LIMIT = HC_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              last_r;
    logic              last_nxt_s;
    logic [HC_W-1:0]   hold_cnt_r;
    logic [HC_W-1:0]   hold_nxt_s;
    logic [1:0]        rdv_r;
    logic [1:0]        rdv_nxt_s;

    logic              req0_s;
    logic              req1_s;
    logic              gnt_vld_s;
    logic              gnt_idx_s;
    logic              gnt_lock_s;
    logic              sel1_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Grant decision; reset_n is included so nothing is granted while in reset
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = 1'b0;
        if (reset_n && !freeze) begin
            case (state_r)
                ARB: begin
                    if (req0_s && req1_s) begin
                        gnt_vld_s = 1'b1;
                        gnt_idx_s = ~last_r;
                    end else if (req0_s) begin
                        gnt_vld_s = 1'b1;
                        gnt_idx_s = 1'b0;
                    end else if (req1_s) begin
                        gnt_vld_s = 1'b1;
                        gnt_idx_s = 1'b1;
                    end else begin
                        gnt_vld_s = 1'b0;
                        gnt_idx_s = 1'b0;
                    end
                end
                OWN0: begin
                    if (req0_s) begin
                        gnt_vld_s = 1'b1;
                        gnt_idx_s = 1'b0;
                    end else begin
                        gnt_vld_s = 1'b0;
                        gnt_idx_s = 1'b0;
                    end
                end
                OWN1: begin
                    if (req1_s) begin
                        gnt_vld_s = 1'b1;
                        gnt_idx_s = 1'b1;
                    end else begin
                        gnt_vld_s = 1'b0;
                        gnt_idx_s = 1'b0;
                    end
                end
                default: begin
                    gnt_vld_s = 1'b0;
                    gnt_idx_s = 1'b0;
                end
            endcase
        end else begin
            gnt_vld_s = 1'b0;
            gnt_idx_s = 1'b0;
        end
    end

    assign gnt_lock_s = gnt_idx_s ? m1_lock : m0_lock;

    // Next-state, round-robin pointer and lock hold counter
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        hold_nxt_s  = hold_cnt_r;
        if (freeze) begin
            state_nxt_s = state_r;
            last_nxt_s  = last_r;
            hold_nxt_s  = hold_cnt_r;
        end else begin
            if (gnt_vld_s) begin
                last_nxt_s = gnt_idx_s;
            end else begin
                last_nxt_s = last_r;
            end
            case (state_r)
                ARB: begin
                    if (gnt_vld_s && gnt_lock_s) begin
                        state_nxt_s = gnt_idx_s ? OWN1 : OWN0;
                        hold_nxt_s  = HC_ONE;
                    end else begin
                        state_nxt_s = ARB;
                        hold_nxt_s  = hold_cnt_r;
                    end
                end
                // The counter runs whether or not the owner is accessing, so an
                // idle owner cannot starve the other master indefinitely.
                OWN0: begin
                    if (!m0_lock || (hold_cnt_r == HC_LIMIT)) begin
                        state_nxt_s = ARB;
                        hold_nxt_s  = HC_ZERO;
                    end else begin
                        state_nxt_s = OWN0;
                        hold_nxt_s  = hold_cnt_r + HC_ONE;
                    end
                end
                OWN1: begin
                    if (!m1_lock || (hold_cnt_r == HC_LIMIT)) begin
                        state_nxt_s = ARB;
                        hold_nxt_s  = HC_ZERO;
                    end else begin
                        state_nxt_s = OWN1;
                        hold_nxt_s  = hold_cnt_r + HC_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ARB;
                    hold_nxt_s  = HC_ZERO;
                end
            endcase
        end
    end

    // A granted read produces valid data on the following cycle. Under freeze
    // there is no grant, so these flags clear while an in-flight read completes.
    always_comb begin
        rdv_nxt_s    = 2'b00;
        rdv_nxt_s[0] = gnt_vld_s & ~gnt_idx_s & m0_read;
        rdv_nxt_s[1] = gnt_vld_s &  gnt_idx_s & m1_read;
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ARB;
            last_r     <= 1'b1;
            hold_cnt_r <= HC_ZERO;
            rdv_r      <= 2'b00;
        end else begin
            state_r    <= state_nxt_s;
            last_r     <= last_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            rdv_r      <= rdv_nxt_s;
        end
    end

    // When nothing is granted the data path defaults to master 0's values
    assign sel1_s = gnt_vld_s & gnt_idx_s;

    assign mem_address    = sel1_s ? m1_address    : m0_address;
    assign mem_writedata  = sel1_s ? m1_writedata  : m0_writedata;
    assign mem_byteenable = sel1_s ? m1_byteenable : m0_byteenable;
    assign mem_chipselect = gnt_vld_s;
    assign mem_write      = gnt_vld_s & (sel1_s ? m1_write : m0_write);
    assign mem_clken      = ~freeze;

    assign m0_waitrequest = ~(gnt_vld_s & ~gnt_idx_s);
    assign m1_waitrequest = ~(gnt_vld_s &  gnt_idx_s);

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rdv_r[0];
    assign m1_readdatavalid = rdv_r[1];

endmodule
